// File: rtl/cmult_rr_arbiter.sv
// cmult_rr_arbiter: round-robin time-sharing of one complex multiplier
// between NREQ requesters. A {valid, id} tag rides alongside each issue
// through a shift register matched to the multiplier latency, so every
// product is steered back to the requester that issued it.
//
// Handshake: a requester presents operands with req_valid[i] and must hold
// them stable until it sees req_ready[i]; a transfer happens on any rising
// edge where req_valid[i] & req_ready[i]. req_ready is a one-hot grant that
// never asserts without the matching req_valid. The result side has no
// backpressure: res_valid is a one-cycle strobe.
module cmult_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int AWIDTH   = 16,
  parameter int BWIDTH   = 16,
  parameter int OUTWIDTH = 33,
  parameter int MULT_LAT = 4,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int IFW     = $clog2(MULT_LAT + 2)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AWIDTH-1:0]   req_a_real,
  input  logic [NREQ*AWIDTH-1:0]   req_a_imag,
  input  logic [NREQ*BWIDTH-1:0]   req_b_real,
  input  logic [NREQ*BWIDTH-1:0]   req_b_imag,
  output logic                     m_valid,
  output logic [AWIDTH-1:0]        m_a_real,
  output logic [AWIDTH-1:0]        m_a_imag,
  output logic [BWIDTH-1:0]        m_b_real,
  output logic [BWIDTH-1:0]        m_b_imag,
  input  logic [OUTWIDTH-1:0]      m_z_real,
  input  logic [OUTWIDTH-1:0]      m_z_imag,
  output logic [NREQ-1:0]          res_valid,
  output logic [OUTWIDTH-1:0]      res_real,
  output logic [OUTWIDTH-1:0]      res_imag,
  output logic [IDW-1:0]           res_id,
  output logic [IFW-1:0]           inflight
);

  // Round-robin pointer: the requester searched first this cycle.
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      ptr_next;
  // Winner of this cycle's search.
  logic [IDW-1:0]      gidx;
  logic                gany;
  logic                xfer;

  // Operands of the winning requester.
  logic [AWIDTH-1:0]   sel_a_real;
  logic [AWIDTH-1:0]   sel_a_imag;
  logic [BWIDTH-1:0]   sel_b_real;
  logic [BWIDTH-1:0]   sel_b_imag;

  // Tag pipeline: stage 0 lines up with m_valid, stage MULT_LAT with m_z_*.
  logic [MULT_LAT:0]   tag_v;
  logic [IDW-1:0]      tag_id [MULT_LAT+1];

  // Search from ptr upward, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    int idx;
    gany = 1'b0;
    gidx = '0;
    idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gany && req_valid[idx]) begin
        gany = 1'b1;
        gidx = IDW'(idx);
      end
    end
  end

  // One-hot grant; held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (gany && rst_n) req_ready[gidx] = 1'b1;
  end

  assign xfer     = gany & rst_n;
  assign ptr_next = (int'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);

  // Operand mux selecting the granted requester's slices.
  always_comb begin
    sel_a_real = '0;
    sel_a_imag = '0;
    sel_b_real = '0;
    sel_b_imag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IDW'(i)) begin
        sel_a_real = req_a_real[i*AWIDTH +: AWIDTH];
        sel_a_imag = req_a_imag[i*AWIDTH +: AWIDTH];
        sel_b_real = req_b_real[i*BWIDTH +: BWIDTH];
        sel_b_imag = req_b_imag[i*BWIDTH +: BWIDTH];
      end
    end
  end

  // Issue register: advance the pointer and launch operands on a transfer;
  // operands hold between issues so the multiplier inputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      m_valid  <= 1'b0;
      m_a_real <= '0;
      m_a_imag <= '0;
      m_b_real <= '0;
      m_b_imag <= '0;
    end else begin
      m_valid <= xfer;
      if (xfer) begin
        ptr      <= ptr_next;
        m_a_real <= sel_a_real;
        m_a_imag <= sel_a_imag;
        m_b_real <= sel_b_real;
        m_b_imag <= sel_b_imag;
      end
    end
  end

  // Tag shift register; clearing it on reset discards in-flight results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int k = 0; k <= MULT_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_v     <= {tag_v[MULT_LAT-1:0], xfer};
      tag_id[0] <= gidx;
      for (int k = 1; k <= MULT_LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  // Result register: capture the product when its tag emerges; data holds
  // between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= '0;
      res_real  <= '0;
      res_imag  <= '0;
      res_id    <= '0;
    end else begin
      res_valid <= '0;
      if (tag_v[MULT_LAT]) begin
        res_valid[tag_id[MULT_LAT]] <= 1'b1;
        res_real                    <= m_z_real;
        res_imag                    <= m_z_imag;
        res_id                      <= tag_id[MULT_LAT];
      end
    end
  end

  // Outstanding-operation count: up on a transfer, down while a result strobe
  // is visible; both at once leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({xfer, |res_valid})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_cmult_rr_arbiter.sv
// Testbench for cmult_rr_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model (round-robin rule, complex
// product arithmetic, expected-result queue with due cycles).
module tb_cmult_rr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int BW   = 16;
  localparam int OW   = 33;
  localparam int LAT  = 4;
  localparam int IDW  = 2;
  localparam int IFW  = 3;
  localparam int EW   = 32 + IDW + 2*OW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_a_real, req_a_imag;
  logic [NREQ*BW-1:0] req_b_real, req_b_imag;
  logic               m_valid;
  logic [AW-1:0]      m_a_real, m_a_imag;
  logic [BW-1:0]      m_b_real, m_b_imag;
  logic [OW-1:0]      m_z_real, m_z_imag;
  logic [NREQ-1:0]    res_valid;
  logic [OW-1:0]      res_real, res_imag;
  logic [IDW-1:0]     res_id;
  logic [IFW-1:0]     inflight;

  cmult_rr_arbiter #(
    .NREQ(NREQ), .AWIDTH(AW), .BWIDTH(BW), .OUTWIDTH(OW), .MULT_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_real(req_a_real), .req_a_imag(req_a_imag),
    .req_b_real(req_b_real), .req_b_imag(req_b_imag),
    .m_valid(m_valid),
    .m_a_real(m_a_real), .m_a_imag(m_a_imag),
    .m_b_real(m_b_real), .m_b_imag(m_b_imag),
    .m_z_real(m_z_real), .m_z_imag(m_z_imag),
    .res_valid(res_valid), .res_real(res_real), .res_imag(res_imag),
    .res_id(res_id), .inflight(inflight)
  );

  // Complex product, 33-bit wrap of the exact result.
  function automatic logic [2*OW-1:0] cmul(input logic [AW-1:0] ar, input logic [AW-1:0] ai,
                                           input logic [BW-1:0] br, input logic [BW-1:0] bi);
    longint r;
    longint i;
    r = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ai)) * longint'($signed(bi));
    i = longint'($signed(ar)) * longint'($signed(bi)) + longint'($signed(ai)) * longint'($signed(br));
    return {r[OW-1:0], i[OW-1:0]};
  endfunction

  // Shared multiplier stand-in: fixed LAT-cycle pipeline, no stall.
  logic [OW-1:0] zr_pipe [LAT];
  logic [OW-1:0] zi_pipe [LAT];
  always @(posedge clk) begin
    {zr_pipe[0], zi_pipe[0]} <= cmul(m_a_real, m_a_imag, m_b_real, m_b_imag);
    for (int k = 1; k < LAT; k++) begin
      zr_pipe[k] <= zr_pipe[k-1];
      zi_pipe[k] <= zi_pipe[k-1];
    end
  end
  assign m_z_real = zr_pipe[LAT-1];
  assign m_z_imag = zi_pipe[LAT-1];

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int mptr     = 0;
  int last_g   = -1;
  int obs_cnt [NREQ];
  logic [EW-1:0]  exp_q [$];   // {due cycle, id, real, imag}
  int             issue_q [$]; // transfer edge numbers not yet retired
  logic [63:0]    exp_ops;
  logic [IDW-1:0] last_id;
  logic [OW-1:0]  last_re, last_im;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    issue_q.delete();
    mptr    = 0;
    exp_ops = '0;
    last_id = '0;
    last_re = '0;
    last_im = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"},    64'(req_ready), 64'd0);
    check_eq({tag, "_mvalid"},   64'(m_valid), 64'd0);
    check_eq({tag, "_mops"},     {m_a_real, m_a_imag, m_b_real, m_b_imag}, 64'd0);
    check_eq({tag, "_resvalid"}, 64'(res_valid), 64'd0);
    check_eq({tag, "_resreal"},  64'(res_real), 64'd0);
    check_eq({tag, "_resimag"},  64'(res_imag), 64'd0);
    check_eq({tag, "_resid"},    64'(res_id), 64'd0);
    check_eq({tag, "_inflight"}, 64'(inflight), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int i, input int ar, input int ai, input int br, input int bi);
    req_a_real[i*AW +: AW] = AW'(ar);
    req_a_imag[i*AW +: AW] = AW'(ai);
    req_b_real[i*BW +: BW] = BW'(br);
    req_b_imag[i*BW +: BW] = BW'(bi);
  endtask

  function automatic int pick16();
    case ($urandom_range(0, 7))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic rand_ops(input int i);
    set_ops(i, pick16(), pick16(), pick16(), pick16());
  endtask

  // One clock: predict the grant from the current inputs, log the expected
  // transaction, advance, then check everything the DUT shows after the edge.
  task automatic step();
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] exp_rv;
    logic [EW-1:0]   e;
    logic [2*OW-1:0] p;
    int g;
    int idx;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (mptr + k) % NREQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check_eq("req_ready", 64'(req_ready), 64'(eg));
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_cnt[i]++;
    last_g = g;
    if (g >= 0) begin
      exp_ops = {req_a_real[g*AW +: AW], req_a_imag[g*AW +: AW],
                 req_b_real[g*BW +: BW], req_b_imag[g*BW +: BW]};
      p = cmul(req_a_real[g*AW +: AW], req_a_imag[g*AW +: AW],
               req_b_real[g*BW +: BW], req_b_imag[g*BW +: BW]);
      exp_q.push_back({32'(cyc + LAT + 2), IDW'(g), p});
      issue_q.push_back(cyc + 1);
      mptr = (g + 1) % NREQ;
    end
    @(posedge clk);
    cyc++;
    #1;
    check_eq("m_valid", 64'(m_valid), 64'(g >= 0));
    check_eq("m_ops", {m_a_real, m_a_imag, m_b_real, m_b_imag}, exp_ops);
    while (issue_q.size() > 0 && issue_q[0] + LAT + 2 <= cyc) void'(issue_q.pop_front());
    check_eq("inflight", 64'(inflight), 64'(issue_q.size()));
    exp_rv = '0;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      if (int'(e[EW-1 -: 32]) == cyc) begin
        void'(exp_q.pop_front());
        exp_rv[e[2*OW +: IDW]] = 1'b1;
        last_id = e[2*OW +: IDW];
        last_re = e[OW +: OW];
        last_im = e[0 +: OW];
      end
    end
    check_eq("res_valid", 64'(res_valid), 64'(exp_rv));
    check_eq("res_real", 64'(res_real), 64'(last_re));
    check_eq("res_imag", 64'(res_imag), 64'(last_im));
    check_eq("res_id", 64'(res_id), 64'(last_id));
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NREQ; i++) obs_cnt[i] = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    clear_counts();
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) rand_ops(i);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester 1, continuously valid: (3-2j)*(5+7j) = 29+11j.
    req_valid = 4'b0010;
    set_ops(1, 3, -2, 5, 7);
    for (int i = 0; i < 12; i++) step();
    check_eq("t1_real", 64'(res_real), 64'd29);
    check_eq("t1_imag", 64'(res_imag), 64'd11);

    // Three in flight, then a short reset pulse: nothing comes back.
    idle(10);
    req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    #3;
    rst_n = 1'b1;
    model_clear();
    idle(10);
    check_eq("midrst_inflight", 64'(inflight), 64'd0);

    // All four valid from a fresh pointer: 25 grants each over 100 cycles.
    clear_counts();
    for (int i = 0; i < NREQ; i++) rand_ops(i);
    req_valid = '1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (last_g >= 0) rand_ops(last_g);
    end
    for (int i = 0; i < NREQ; i++) check_eq($sformatf("t2_cnt%0d", i), 64'(obs_cnt[i]), 64'd25);
    idle(LAT + 3);

    // Pointer at 1, requesters 0 and 2 valid: 2 first, then alternating.
    req_valid = 4'b0001;
    step();
    clear_counts();
    req_valid = 4'b0101;
    for (int i = 0; i < 10; i++) step();
    check_eq("t3_cnt0", 64'(obs_cnt[0]), 64'd5);
    check_eq("t3_cnt1", 64'(obs_cnt[1]), 64'd0);
    check_eq("t3_cnt2", 64'(obs_cnt[2]), 64'd5);
    check_eq("t3_cnt3", 64'(obs_cnt[3]), 64'd0);
    idle(LAT + 3);

    // Extreme operands: (-32768-32768j)^2 = 0 + 2^31 j.
    set_ops(3, -32768, -32768, -32768, -32768);
    req_valid = 4'b1000;
    step();
    idle(LAT + 3);
    check_eq("t4_real", 64'(res_real), 64'd0);
    check_eq("t4_imag", 64'(res_imag), 64'h0_8000_0000);
    check_eq("t4_id", 64'(res_id), 64'd3);

    // Long idle, then a lone request is granted on its first valid cycle.
    idle(20);
    clear_counts();
    rand_ops(2);
    req_valid = 4'b0100;
    step();
    check_eq("t5_grant2", 64'(obs_cnt[2]), 64'd1);
    idle(LAT + 3);

    // Randomized traffic: valids toggle freely, operands held until granted.
    for (int i = 0; i < NREQ; i++) rand_ops(i);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(0, 3) != 0);
      step();
      if (last_g >= 0) rand_ops(last_g);
    end
    idle(LAT + 4);
    check_eq("drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
